// File: rtl/controller_mc_if.sv
// Host register bus between a bus master and controller_mc.
// Handshake: a write happens on every cycle slave_wrreq=1 and slave_wrack
// follows one cycle later; a read is requested on every cycle slave_rdreq=1,
// and slave_rdack plus slave_dataout follow one cycle later.
interface controller_mc_if #(
   parameter int ADDRESS_SIZE = 36,
   parameter int DATA_WIDTH   = 128
);
   logic [ADDRESS_SIZE-1:0] slave_address;
   logic                    slave_wrreq;
   logic                    slave_wrack;
   logic [DATA_WIDTH-1:0]   slave_datain;
   logic                    slave_rdreq;
   logic                    slave_rdack;
   logic [DATA_WIDTH-1:0]   slave_dataout;

   modport master (
      output slave_address, slave_wrreq, slave_datain, slave_rdreq,
      input  slave_wrack, slave_rdack, slave_dataout
   );

   modport slave (
      input  slave_address, slave_wrreq, slave_datain, slave_rdreq,
      output slave_wrack, slave_rdack, slave_dataout
   );
endinterface

// File: rtl/controller_mc.sv
// Multi-channel command controller: host register file plus one
// IDLE/ISSUE/WAIT command FSM per channel with done/overrun status and irq.
module controller_mc #(
   parameter int ADDRESS_SIZE = 36,
   parameter int DATA_WIDTH   = 128,
   parameter int NUM_CH       = 2,
   parameter int REG_LSB      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   controller_mc_if.slave               host,
   output logic [NUM_CH*DATA_WIDTH-1:0] cmd_data,
   output logic [NUM_CH-1:0]            cmd_valid,
   input  logic [NUM_CH-1:0]            cmd_ready,
   input  logic [NUM_CH-1:0]            cmd_complete,
   output logic                         irq,
   output logic [2*NUM_CH-1:0]          ch_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} ch_state_e;

   localparam int CMD_W = 92;

   logic [ADDRESS_SIZE-1:0] addr_w;
   logic [3:0]              idx;
   logic                    wr_geom, wr_ctrl, wr_status, wr_irqen;
   logic [23:0]             geom_q;
   logic [35:0]             pix_len_q;
   logic [NUM_CH-1:0]       irqen_q, done_q, ovr_q, busy;
   logic [NUM_CH-1:0]       set_done, set_ovr, clr_done, clr_ovr, wr_desc;
   logic [55:0]             desc_q [NUM_CH];
   logic [23:0]             status_w;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    unused_bits;

   assign addr_w    = host.slave_address;
   assign idx       = addr_w[REG_LSB+3:REG_LSB];
   assign wr_geom   = host.slave_wrreq && (idx == 4'd0);
   assign wr_ctrl   = host.slave_wrreq && (idx == 4'd1);
   assign wr_status = host.slave_wrreq && (idx == 4'd2);
   assign wr_irqen  = host.slave_wrreq && (idx == 4'd3);
   assign clr_done  = wr_status ? host.slave_datain[8 +: NUM_CH]  : '0;
   assign clr_ovr   = wr_status ? host.slave_datain[16 +: NUM_CH] : '0;
   assign irq       = |(done_q & irqen_q);
   assign unused_bits = ^{addr_w, host.slave_datain};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ch_state_e             state_q, state_d;
      logic [DATA_WIDTH-1:0] cmd_q, cmd_next;
      logic                  start, done_pulse;

      assign start      = wr_ctrl & host.slave_datain[c];
      assign busy[c]    = (state_q != IDLE);
      assign set_ovr[c] = start & busy[c];
      assign set_done[c] = done_pulse;
      assign wr_desc[c] = host.slave_wrreq && (idx == 4'(4 + c));
      assign cmd_valid[c] = (state_q == ISSUE);
      assign cmd_data[c*DATA_WIDTH +: DATA_WIDTH] = cmd_q;
      assign ch_state[2*c +: 2] = state_q;

      always_comb begin
         cmd_next = '0;
         cmd_next[CMD_W-1:0] = {desc_q[c][35:0], pix_len_q,
                                desc_q[c][51:36], desc_q[c][55:52]};
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
         end else begin
            state_q <= state_d;
            // Command is frozen here, so later DESC writes cannot disturb it.
            if ((state_q == IDLE) && start) cmd_q <= cmd_next;
         end
      end

      always_comb begin
         state_d    = state_q;
         done_pulse = 1'b0;
         case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: if (cmd_ready[c]) state_d = WAIT;
            WAIT: begin
               if (cmd_complete[c]) begin
                  state_d    = IDLE;
                  done_pulse = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      status_w = '0;
      status_w[NUM_CH-1:0]   = busy;
      status_w[8 +: NUM_CH]  = done_q;
      status_w[16 +: NUM_CH] = ovr_q;
      rd_data = '0;
      case (idx)
         4'd0: rd_data[23:0] = geom_q;
         4'd1: rd_data = '0;
         4'd2: rd_data[23:0] = status_w;
         4'd3: rd_data[NUM_CH-1:0] = irqen_q;
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (idx == 4'(4 + c)) rd_data[55:0] = desc_q[c];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         geom_q             <= '0;
         pix_len_q          <= '0;
         irqen_q            <= '0;
         done_q             <= '0;
         ovr_q              <= '0;
         host.slave_wrack   <= 1'b0;
         host.slave_rdack   <= 1'b0;
         host.slave_dataout <= '0;
         for (int c = 0; c < NUM_CH; c++) desc_q[c] <= '0;
      end else begin
         host.slave_wrack <= host.slave_wrreq;
         host.slave_rdack <= host.slave_rdreq;
         if (host.slave_rdreq) host.slave_dataout <= rd_data;
         pix_len_q <= 36'(geom_q[11:0]) + 36'(geom_q[23:12]);
         if (wr_geom)  geom_q  <= host.slave_datain[23:0];
         if (wr_irqen) irqen_q <= host.slave_datain[NUM_CH-1:0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_desc[c]) desc_q[c] <= host.slave_datain[55:0];
         end
         // Sets are OR-ed in after the clear so a coinciding event wins.
         done_q <= (done_q & ~clr_done) | set_done;
         ovr_q  <= (ovr_q & ~clr_ovr) | set_ovr;
      end
   end

endmodule

// File: tb/tb_controller_mc.sv
// Directed bench for controller_mc with a register-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_controller_mc;
   localparam int NCH = 2;
   localparam int DW  = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [NCH*DW-1:0] cmd_data;
   logic [NCH-1:0]    cmd_valid;
   logic [NCH-1:0]    cmd_ready    = '0;
   logic [NCH-1:0]    cmd_complete = '0;
   logic              irq;
   logic [2*NCH-1:0]  ch_state;

   int check_count = 0;
   int pass_count  = 0;

   controller_mc_if #(.ADDRESS_SIZE(36), .DATA_WIDTH(DW)) host_if ();

   controller_mc #(
      .ADDRESS_SIZE(36), .DATA_WIDTH(DW), .NUM_CH(NCH), .REG_LSB(4)
   ) dut (
      .clk(clk), .rst(rst), .host(host_if.slave),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_complete(cmd_complete), .irq(irq), .ch_state(ch_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [23:0]    m_geom  = '0;
   logic [35:0]    m_pix   = '0;
   logic [NCH-1:0] m_irqen = '0, m_done = '0, m_ovr = '0, m_pend = '0, m_outs = '0;
   logic [55:0]    m_desc [NCH];
   logic [DW-1:0]  m_cmd [NCH];
   logic           m_wrack = 1'b0, m_rdack = 1'b0;
   logic [DW-1:0]  m_dout = '0;

   function automatic logic [DW-1:0] model_read(input logic [3:0] i);
      logic [DW-1:0] r;
      r = '0;
      case (i)
         4'd0: r[23:0] = m_geom;
         4'd2: begin
            r[1:0]   = m_pend | m_outs;
            r[9:8]   = m_done;
            r[17:16] = m_ovr;
         end
         4'd3: r[1:0] = m_irqen;
         4'd4: r[55:0] = m_desc[0];
         4'd5: r[55:0] = m_desc[1];
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_geom = '0; m_pix = '0; m_irqen = '0; m_done = '0; m_ovr = '0;
      m_pend = '0; m_outs = '0; m_wrack = 1'b0; m_rdack = 1'b0; m_dout = '0;
      for (int c = 0; c < NCH; c++) begin
         m_desc[c] = '0;
         m_cmd[c]  = '0;
      end
   endtask

   task automatic model_step();
      logic [3:0]    i;
      logic [DW-1:0] wd;
      logic          wr, rd, start, was_busy;
      logic [35:0]   old_pix;
      logic [55:0]   od [NCH];
      i  = host_if.slave_address[7:4];
      wd = host_if.slave_datain;
      wr = host_if.slave_wrreq;
      rd = host_if.slave_rdreq;
      if (rd) m_dout = model_read(i);
      m_rdack = rd;
      m_wrack = wr;
      old_pix = m_pix;
      for (int c = 0; c < NCH; c++) od[c] = m_desc[c];
      m_pix = 36'(m_geom[11:0]) + 36'(m_geom[23:12]);
      if (wr && i == 4'd2) begin
         m_done = m_done & ~wd[9:8];
         m_ovr  = m_ovr & ~wd[17:16];
      end
      for (int c = 0; c < NCH; c++) begin
         start    = wr && (i == 4'd1) && wd[c];
         was_busy = m_pend[c] | m_outs[c];
         if (m_pend[c] && cmd_ready[c]) begin
            m_pend[c] = 1'b0;
            m_outs[c] = 1'b1;
         end else if (m_outs[c] && cmd_complete[c]) begin
            m_outs[c] = 1'b0;
            m_done[c] = 1'b1;
         end
         if (start && was_busy) m_ovr[c] = 1'b1;
         else if (start) begin
            m_pend[c] = 1'b1;
            m_cmd[c]  = DW'({od[c][35:0], old_pix, od[c][51:36], od[c][55:52]});
         end
      end
      if (wr && i == 4'd0) m_geom = wd[23:0];
      if (wr && i == 4'd3) m_irqen = wd[1:0];
      if (wr && i == 4'd4) m_desc[0] = wd[55:0];
      if (wr && i == 4'd5) m_desc[1] = wd[55:0];
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      check_count++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass_count++;
   endtask

   // per-cycle comparison against the model, mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         check("wrack", 256'(host_if.slave_wrack), 256'(m_wrack));
         check("rdack", 256'(host_if.slave_rdack), 256'(m_rdack));
         check("dataout", 256'(host_if.slave_dataout), 256'(m_dout));
         check("cmd_valid", 256'(cmd_valid), 256'(m_pend));
         for (int c = 0; c < NCH; c++) begin
            if (m_pend[c]) check("cmd_data", 256'(cmd_data[c*DW +: DW]), 256'(m_cmd[c]));
         end
         check("irq", 256'(irq), 256'(|(m_done & m_irqen)));
      end
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic bus_write(input int i, input logic [DW-1:0] d);
      host_if.slave_address = 36'(i) << 4;
      host_if.slave_datain  = d;
      host_if.slave_wrreq   = 1'b1;
      step();
      host_if.slave_wrreq   = 1'b0;
   endtask

   task automatic bus_read(input int i, output logic [DW-1:0] d);
      host_if.slave_address = 36'(i) << 4;
      host_if.slave_rdreq   = 1'b1;
      step();
      host_if.slave_rdreq   = 1'b0;
      d = host_if.slave_dataout;
   endtask

   localparam logic [55:0] DESC0_A = 56'h7_0040_000001000;
   localparam logic [55:0] DESC0_B = 56'h3_1234_0000ABCDE;
   localparam logic [55:0] DESC1   = 56'h5_0010_000002000;
   localparam logic [DW-1:0] CMD0_A = 128'h000001000_00000001E_0040_7;

   logic [DW-1:0] rd;

   initial begin
      host_if.slave_address = '0;
      host_if.slave_datain  = '0;
      host_if.slave_wrreq   = 1'b0;
      host_if.slave_rdreq   = 1'b0;
      step();
      step();
      check("reset_valid", 256'(cmd_valid), 256'(0));
      check("reset_irq", 256'(irq), 256'(0));
      check("reset_dout", 256'(host_if.slave_dataout), 256'(0));
      rst = 1'b1;
      step();

      // single-channel run with backpressure and a DESC rewrite in flight
      bus_write(0, 128'h00A014);
      bus_write(4, 128'(DESC0_A));
      bus_write(1, 128'h1);
      check("start_valid", 256'(cmd_valid), 256'(2'b01));
      check("start_cmd", 256'(cmd_data[DW-1:0]), 256'(CMD0_A));
      for (int k = 0; k < 5; k++) begin
         if (k == 2) bus_write(4, 128'(DESC0_B));
         else step();
         check("bp_valid", 256'(cmd_valid[0]), 256'(1));
         check("bp_cmd", 256'(cmd_data[DW-1:0]), 256'(CMD0_A));
      end
      cmd_ready = 2'b01;
      step();
      cmd_ready = 2'b00;
      check("wait_valid", 256'(cmd_valid), 256'(0));

      // overrun during WAIT, then completion and W1C
      bus_write(1, 128'h1);
      bus_read(2, rd);
      check("status_ovr", 256'(rd), 256'(24'h010001));
      cmd_complete = 2'b01;
      step();
      cmd_complete = 2'b00;
      bus_read(2, rd);
      check("status_done", 256'(rd), 256'(24'h010100));
      bus_write(2, 128'h010100);
      bus_read(2, rd);
      check("status_clr", 256'(rd), 256'(0));

      // register map corners
      bus_read(0, rd);
      check("geom_rd", 256'(rd), 256'(24'h00A014));
      bus_read(1, rd);
      check("ctrl_rd", 256'(rd), 256'(0));
      bus_read(4, rd);
      check("desc0_rd", 256'(rd), 256'(DESC0_B));
      bus_write(15, '1);
      bus_read(15, rd);
      check("unmapped15", 256'(rd), 256'(0));
      bus_read(6, rd);
      check("unmapped6", 256'(rd), 256'(0));

      // both channels, interrupts, W1C colliding with a new done
      bus_write(3, 128'h3);
      bus_read(3, rd);
      check("irqen_rd", 256'(rd), 256'(2'b11));
      bus_write(1, 128'h3);
      check("dual_valid", 256'(cmd_valid), 256'(2'b11));
      cmd_ready = 2'b11;
      step();
      cmd_ready = 2'b00;
      cmd_complete = 2'b11;
      step();
      cmd_complete = 2'b00;
      check("irq_both", 256'(irq), 256'(1));
      bus_read(2, rd);
      check("status_both", 256'(rd), 256'(24'h000300));
      bus_write(1, 128'h1);
      cmd_ready = 2'b01;
      step();
      cmd_ready = 2'b00;
      cmd_complete = 2'b01;
      bus_write(2, 128'h000100);
      cmd_complete = 2'b00;
      bus_read(2, rd);
      check("status_setwins", 256'(rd), 256'(24'h000300));
      check("irq_setwins", 256'(irq), 256'(1));
      bus_write(2, 128'h000300);
      check("irq_cleared", 256'(irq), 256'(0));

      // reset mid-operation on ch1 with done pending on ch0
      bus_write(1, 128'h1);
      cmd_ready = 2'b01;
      step();
      cmd_ready = 2'b00;
      cmd_complete = 2'b01;
      step();
      cmd_complete = 2'b00;
      check("irq_pre_rst", 256'(irq), 256'(1));
      bus_write(5, 128'(DESC1));
      bus_read(5, rd);
      check("desc1_rd", 256'(rd), 256'(DESC1));
      bus_write(1, 128'h2);
      check("ch1_valid", 256'(cmd_valid), 256'(2'b10));
      rst = 1'b0;
      #1;
      check("rst_valid", 256'(cmd_valid), 256'(0));
      check("rst_irq", 256'(irq), 256'(0));
      step();
      step();
      rst = 1'b1;
      cmd_complete = 2'b10;
      step();
      cmd_complete = 2'b00;
      bus_read(2, rd);
      check("post_rst_status", 256'(rd), 256'(0));
      check("post_rst_irq", 256'(irq), 256'(0));
      step();
      step();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
